// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the control unit's SRAM bus.
//
// A 256 x 16 single-port word memory with a byte-stream program loader.
// After reset the loader fills memory from address 0 upward (high byte of
// each word first) while cpu_hold keeps the CPU in reset. The load ends on
// ld_last (qualifying a low byte) or when the word pointer wraps past 255.
// The block then serves bus reads and writes until the next reset.
//
// Read timing: a read presented with sram_en = 0 is accepted at the next
// rising edge. rdata/rvalid appear after READ_LATENCY edges, counting the
// accepting edge as the first. With READ_LATENCY = 1 the data is therefore
// visible in the cycle right after the request (enable in IF1, capture in
// IF2).
//
// Optional feature macro: MEM_WP_EN. When defined, bus writes to addresses
// below WP_LIMIT are dropped and pulse wp_fault. Loader writes always land.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high
//   sram_en   in   bus enable, active low
//   write_en  in   0 = write, 1 = read (only while sram_en = 0)
//   address   in   [7:0]  word address
//   wdata     in   [0:15] write data, bit 0 = MSB
//   rdata     out  [0:15] read data, bit 0 = MSB; holds between reads
//   rvalid    out  one-cycle pulse when rdata is updated by a read
//   ld_valid  in   loader byte present
//   ld_data   in   [7:0] loader byte
//   ld_last   in   marks the low byte of the final word
//   ld_ready  out  loader byte accepted this edge
//   cpu_hold  out  high while loading
//   wp_fault  out  one-cycle pulse on a dropped protected write
module mem_responder #(
  parameter int READ_LATENCY = 1,
  parameter int WP_LIMIT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic        write_en,
  input  logic [7:0]  address,
  input  logic [0:15] wdata,
  output logic [0:15] rdata,
  output logic        rvalid,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_hold,
  output logic        wp_fault
);

  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, SERVE} state_t;

  state_t r_state, w_next;

  logic [7:0]  r_ptr;
  logic [7:0]  r_hi_byte;
  logic [0:15] r_mem [256];

  logic [READ_LATENCY-1:0][0:15] r_pipe_d;
  logic [READ_LATENCY-1:0]       r_pipe_v;
  logic                          r_wp_fault;

  logic        w_serve;
  logic        w_bus_wr;
  logic        w_bus_rd;
  logic        w_wp_hit;
  logic        w_ld_we;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [0:15] w_mem_wdata;

  assign w_serve  = (r_state == SERVE);
  assign w_bus_wr = w_serve && !sram_en && !write_en;
  assign w_bus_rd = w_serve && !sram_en &&  write_en;

`ifdef MEM_WP_EN
  assign w_wp_hit = w_bus_wr && (32'(address) < WP_LIMIT);
`else
  logic w_unused_wp;
  assign w_unused_wp = (WP_LIMIT == 0);
  assign w_wp_hit    = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD_HI;
    else       r_state <= w_next;
  end

  // FSM: next state and loader write strobe
  always_comb begin
    w_next  = r_state;
    w_ld_we = 1'b0;
    case (r_state)
      LOAD_HI: if (ld_valid) w_next = LOAD_LO;
      LOAD_LO: begin
        if (ld_valid) begin
          w_ld_we = 1'b1;
          // wrapping the pointer back to 0 also ends the load
          if (ld_last || r_ptr == 8'hFF) w_next = SERVE;
          else                           w_next = LOAD_HI;
        end
      end
      SERVE:   w_next = SERVE;
      default: w_next = LOAD_HI;
    endcase
  end

  // loader pointer and pending high byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= 8'd0;
      r_hi_byte <= 8'd0;
    end else begin
      if (r_state == LOAD_HI && ld_valid) r_hi_byte <= ld_data;
      if (w_ld_we)                        r_ptr     <= r_ptr + 8'd1;
    end
  end

  // one write port shared by loader and bus; they are never active together
  assign w_mem_we    = w_ld_we || (w_bus_wr && !w_wp_hit);
  assign w_mem_addr  = w_ld_we ? r_ptr : address;
  assign w_mem_wdata = w_ld_we ? {r_hi_byte, ld_data} : wdata;

  // memory contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // read pipeline: stage 0 samples memory at the accepting edge, the last
  // stage is rdata. Data registers only load behind a valid entry so rdata
  // holds its value between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_d <= '0;
      r_pipe_v <= '0;
    end else begin
      r_pipe_v[0] <= w_bus_rd;
      if (w_bus_rd) r_pipe_d[0] <= r_mem[address];
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        if (r_pipe_v[i-1]) r_pipe_d[i] <= r_pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wp_fault <= 1'b0;
    else       r_wp_fault <= w_wp_hit;
  end

  assign rdata    = r_pipe_d[READ_LATENCY-1];
  assign rvalid   = r_pipe_v[READ_LATENCY-1];
  assign ld_ready = !w_serve;
  assign cpu_hold = !w_serve;
  assign wp_fault = r_wp_fault;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized stimulus against a
// behavioural model, plus directed literal checks of the main scenarios.
module tb_mem_responder;
  localparam int RL  = 1;
  localparam int WPL = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_en = 1'b1;
  logic        write_en = 1'b1;
  logic [7:0]  address = 8'd0;
  logic [0:15] wdata = 16'd0;
  logic [0:15] rdata;
  logic        rvalid;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        cpu_hold;
  logic        wp_fault;

  mem_responder #(.READ_LATENCY(RL), .WP_LIMIT(WPL)) dut (
    .clk(clk), .reset(reset), .sram_en(sram_en), .write_en(write_en),
    .address(address), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .wp_fault(wp_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model
  int          m_phase;   // 0: expecting high byte, 1: low byte, 2: serving
  logic [7:0]  m_ptr, m_hi;
  logic [15:0] m_mem [256];
  bit          m_known [256];
  logic [15:0] e_rdata;
  bit          e_rd_known;
  bit          e_rvalid, e_wp;
  int          cyc;
  int          q_due [$];
  logic [15:0] q_dat [$];
  bit          q_kn  [$];
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_hi = 0;
    e_rdata = 0; e_rd_known = 1; e_rvalid = 0; e_wp = 0;
    q_due.delete(); q_dat.delete(); q_kn.delete();
  endtask

  task automatic model_edge();
    cyc++;
    e_rvalid = 0; e_wp = 0;
    if (m_phase == 0) begin
      if (ld_valid) begin m_hi = ld_data; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (ld_valid) begin
        m_mem[m_ptr] = {m_hi, ld_data};
        m_known[m_ptr] = 1;
        m_phase = (ld_last || m_ptr == 8'd255) ? 2 : 0;
        m_ptr = m_ptr + 8'd1;
      end
    end else if (!sram_en) begin
      if (!write_en) begin
`ifdef MEM_WP_EN
        if (int'(address) < WPL) e_wp = 1;
        else m_mem[address] = wdata;
`else
        m_mem[address] = wdata;
`endif
      end else begin
        q_due.push_back(cyc + RL - 1);
        q_dat.push_back(m_mem[address]);
        q_kn.push_back(m_known[address]);
      end
    end
    while (q_due.size() > 0 && q_due[0] == cyc) begin
      void'(q_due.pop_front());
      e_rdata = q_dat.pop_front();
      e_rd_known = q_kn.pop_front();
      e_rvalid = 1;
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ld_ready", {15'd0, ld_ready}, {15'd0, m_phase != 2});
      chk("cpu_hold", {15'd0, cpu_hold}, {15'd0, m_phase != 2});
      chk("rvalid",   {15'd0, rvalid},   {15'd0, e_rvalid});
      chk("wp_fault", {15'd0, wp_fault}, {15'd0, e_wp});
      if (e_rd_known) chk("rdata", rdata, e_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata",    rdata,             16'h0000);
    chk("rst_rvalid",   {15'd0, rvalid},   16'd0);
    chk("rst_ld_ready", {15'd0, ld_ready}, 16'd1);
    chk("rst_cpu_hold", {15'd0, cpu_hold}, 16'd1);
    chk("rst_wp_fault", {15'd0, wp_fault}, 16'd0);
    reset = 1'b0;
  endtask

  task automatic junk_bus();
    sram_en  = 1'($urandom);
    write_en = 1'($urandom);
    address  = 8'($urandom);
    wdata    = 16'($urandom);
  endtask

  task automatic idle_bus();
    sram_en = 1'b1;
    write_en = 1'($urandom);
  endtask

  task automatic ld_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    junk_bus();
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    idle_bus();
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
    sram_en = 1'b0; write_en = 1'b0; address = a; wdata = d;
    step();
    idle_bus();
  endtask

  task automatic bus_rd(input logic [7:0] a);
    sram_en = 1'b0; write_en = 1'b1; address = a;
    step();
    idle_bus();
    repeat (RL - 1) step();
  endtask

  logic [7:0]  bytes [512];
  logic [15:0] saved1;

  initial begin
    cyc = 0;
    for (int i = 0; i < 256; i++) m_known[i] = 0;
    model_reset();
    cmp_en = 1'b1;
    do_reset();

    // basic load; ld_last on a high byte must be ignored
    ld_byte(8'h12, 1'b1);
    ld_byte(8'h34, 1'b0);
    // bus write attempt during load must be ignored
    sram_en = 1'b0; write_en = 1'b0; address = 8'h00; wdata = 16'hFFFF;
    step();
    sram_en = 1'b0; write_en = 1'b1; address = 8'h00;
    step();
    idle_bus();
    ld_byte(8'hAB, 1'b0);
    chk("hold_before_last", {15'd0, cpu_hold}, 16'd1);
    ld_byte(8'hCD, 1'b1);
    chk("hold_after_last",  {15'd0, cpu_hold}, 16'd0);
    chk("ready_after_last", {15'd0, ld_ready}, 16'd0);
    chk("model_mem0", m_mem[0], 16'h1234);
    chk("model_mem1", m_mem[1], 16'hABCD);
    bus_rd(8'h01);
    chk("rd1_data",  rdata, 16'hABCD);
    chk("rd1_valid", {15'd0, rvalid}, 16'd1);
    step();
    chk("rd1_hold",  rdata, 16'hABCD);
    chk("rd1_pulse", {15'd0, rvalid}, 16'd0);
    bus_rd(8'h00);
    chk("rd0_data", rdata, 16'h1234);
    bus_wr(8'h20, 16'h5A5A);
    bus_rd(8'h20);
    chk("raw_data", rdata, 16'h5A5A);
    // loader input after the load is ignored
    ld_byte(8'h99, 1'b1);
    chk("ready_serve", {15'd0, ld_ready}, 16'd0);

    // full 512-byte load with wrap, random gaps, ld_last only on high bytes
    do_reset();
    for (int i = 0; i < 512; i++) begin
      bytes[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin junk_bus(); step(); idle_bus(); end
      ld_byte(bytes[i], (i % 2 == 0) ? 1'($urandom) : 1'b0);
      if (i == 510) chk("hold_before_wrap", {15'd0, cpu_hold}, 16'd1);
    end
    chk("hold_after_wrap", {15'd0, cpu_hold}, 16'd0);
    bus_rd(8'hFF);
    chk("wrap_mem255", rdata, {bytes[510], bytes[511]});
    bus_rd(8'h00);
    chk("wrap_mem0", rdata, {bytes[0], bytes[1]});

    // random serve traffic; compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin sram_en = 0; write_en = 1; address = 8'($urandom); end
        4, 5, 6:    begin sram_en = 0; write_en = 0; address = 8'($urandom);
                          wdata = 16'($urandom); end
        default:    idle_bus();
      endcase
      step();
    end
    idle_bus();
    step();

    // reset right after a read, then reset mid-load
    saved1 = m_mem[1];
    bus_rd(8'h07);
    do_reset();
    ld_byte(8'hAA, 1'b0);
    ld_byte(8'hBB, 1'b0);
    ld_byte(8'hCC, 1'b0);
    do_reset();
    ld_byte(8'h00, 1'b0);
    ld_byte(8'h01, 1'b1);
    bus_rd(8'h00);
    chk("reload_mem0", rdata, 16'h0001);
    bus_rd(8'h01);
    chk("reload_mem1", rdata, saved1);

`ifdef MEM_WP_EN
    bus_rd(8'h05);
    saved1 = rdata;
    bus_wr(8'h05, 16'hFFFF);
    chk("wp_pulse", {15'd0, wp_fault}, 16'd1);
    step();
    chk("wp_pulse_end", {15'd0, wp_fault}, 16'd0);
    bus_rd(8'h05);
    chk("wp_mem5", rdata, saved1);
    bus_wr(8'h10, 16'hFFFF);
    chk("wp_none", {15'd0, wp_fault}, 16'd0);
    bus_rd(8'h10);
    chk("wp_mem16", rdata, 16'hFFFF);
`else
    bus_wr(8'h05, 16'hFFFF);
    chk("nowp_fault", {15'd0, wp_fault}, 16'd0);
    bus_rd(8'h05);
    chk("nowp_mem5", rdata, 16'hFFFF);
`endif

    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
